// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and constants for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker scanning upward from last+1
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    winner,
  output logic             any_valid
);

  int            idx;
  logic [IW-1:0] sel;

  // Walk offsets from farthest to nearest so the nearest valid requester is written last.
  always_comb begin
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = int'(last) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = IW'(idx);
      if (req[sel]) winner = sel;
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter in front of a FIFO write port
// Optional per-requester transfer counters when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WIDTH-1:0]  req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [WIDTH-1:0]        fifo_data,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [N_REQ*STAT_W-1:0] xfer_count
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BURST + 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    grant_idx_q, grant_idx_d;
  logic [IW-1:0]    last_grant_q, last_grant_d;
  logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;

  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             owner_valid;
  logic             xfer;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (req_valid),
    .last      (last_grant_q),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    req_ready    = '0;
    xfer         = 1'b0;
    owner_valid  = req_valid[grant_idx_q];

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d     = ST_GRANT;
          grant_idx_d = pick_idx;
          grant_d     = N_REQ'(1) << pick_idx;
          busy_d      = 1'b1;
          burst_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        req_ready[grant_idx_q] = ~fifo_full;
        xfer                   = owner_valid & ~fifo_full;
        // A full FIFO freezes the grant; release only when the port could have moved.
        if (!fifo_full) begin
          if (!owner_valid || burst_cnt_q == CW'(BURST - 1)) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_idx_q;
            grant_d      = '0;
            busy_d       = 1'b0;
            burst_cnt_d  = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CW'(1);
          end
        end
      end
    endcase

    fifo_wr_en = xfer;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IW'(N_REQ - 1);
      burst_cnt_q  <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
    end
  end

  assign fifo_data = req_data[int'(grant_idx_q) * WIDTH +: WIDTH];
  assign grant     = grant_q;
  assign busy      = busy_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [N_REQ];
  logic [STAT_W-1:0] cnt_d [N_REQ];

  // Clear has priority over a same-cycle transfer; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (xfer && grant_idx_q == IW'(i) && cnt_q[i] != {STAT_W{1'b1}}) begin
        cnt_d[i] = cnt_q[i] + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_flat
    assign xfer_count[gi*STAT_W +: STAT_W] = cnt_q[gi];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter (stats checks under FIFO_WR_ARB_STATS_EN)
module tb_fifo_wr_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data;
  logic [N-1:0]   grant;
  logic           busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic           stats_clr;
  logic [N*16-1:0] xfer_count;
  logic           clr_drv;
`endif

  fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .BURST(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant      (grant),
    .busy       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stats_clr  (stats_clr),
    .xfer_count (xfer_count)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0]   pdata [N][64];
  int           phead [N];
  int           ptail [N];
  logic [N-1:0] en;
  logic         full_drv;

  int           sb_idx [$];
  logic [7:0]   sb_dat [$];

  int           n_checks = 0;
  int           n_pass   = 0;

  logic [N-1:0] s_grant, s_ready;
  logic         s_wr, s_busy;
  logic [7:0]   s_data;

  task automatic push_word(input int i, input logic [7:0] d);
    pdata[i][ptail[i]] = d;
    ptail[i]++;
  endtask

  task automatic expect_w(input int i, input logic [7:0] d);
    sb_idx.push_back(i);
    sb_dat.push_back(d);
  endtask

  // One cycle: drive at negedge, sample 1ns later, score any write, advance producers.
  task automatic tick();
    int           ei;
    logic [7:0]   ed;
    logic [N-1:0] oh;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = en[i] && (phead[i] < ptail[i]);
      req_data[i*W +: W] = pdata[i][phead[i]];
    end
    fifo_full = full_drv;
`ifdef FIFO_WR_ARB_STATS_EN
    stats_clr = clr_drv;
`endif
    #1;
    s_grant = grant;
    s_ready = req_ready;
    s_wr    = fifo_wr_en;
    s_busy  = busy;
    s_data  = fifo_data;
    if (s_wr) begin
      n_checks++;
      if (sb_idx.size() == 0) begin
        $display("FAIL sb_write: got data=%h grant=%b, required no write", s_data, s_grant);
      end else begin
        ei = sb_idx.pop_front();
        ed = sb_dat.pop_front();
        oh = '0;
        oh[ei] = 1'b1;
        if (s_data === ed && s_grant === oh) n_pass++;
        else $display("FAIL sb_write: got data=%h grant=%b, required data=%h grant=%b",
                      s_data, s_grant, ed, oh);
      end
    end
    for (int i = 0; i < N; i++) if (req_valid[i] && s_ready[i]) phead[i]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    full_drv  = 1'b0;
    en        = '1;
`ifdef FIFO_WR_ARB_STATS_EN
    stats_clr = 1'b0;
    clr_drv   = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
    sb_idx.delete();
    sb_dat.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    full_drv  = 1'b0;
    en        = '1;
`ifdef FIFO_WR_ARB_STATS_EN
    stats_clr = 1'b0;
    clr_drv   = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant === '0 && busy === 1'b0) n_pass++;
    else $display("FAIL reset_grant_busy: got grant=%b busy=%b, required 0000/0", grant, busy);
    req_valid = '1;
    req_data  = 32'hD3D2D1D0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (req_ready === '0 && fifo_wr_en === 1'b0) n_pass++;
    else $display("FAIL reset_ready_wr: got ready=%b wr_en=%b, required 0000/0", req_ready, fifo_wr_en);
    n_checks++;
    if (grant === '0) n_pass++;
    else $display("FAIL reset_hold_grant: got %b, required 0000", grant);
  endtask

  task automatic test_single();
    logic [N-1:0] eg [11];
    eg = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
           4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    do_reset();
    for (int j = 0; j < 8; j++) begin
      push_word(0, 8'hA0 + 8'(j));
      expect_w(0, 8'hA0 + 8'(j));
    end
    for (int t = 0; t < 11; t++) begin
      tick();
      n_checks++;
      if (s_grant === eg[t]) n_pass++;
      else $display("FAIL single_grant_t%0d: got %b, required %b", t, s_grant, eg[t]);
    end
    n_checks++;
    if (sb_idx.size() == 0) n_pass++;
    else $display("FAIL single_drain: got %0d pending, required 0", sb_idx.size());
  endtask

  task automatic test_round_robin();
    int           order [5];
    logic [N-1:0] eg;
    order = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4; j++) push_word(i, 8'(i * 16 + j));
    for (int j = 4; j < 8; j++) push_word(0, 8'(j));
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 4; j++) expect_w(order[k], 8'(order[k] * 16 + (k == 4 ? j + 4 : j)));
    for (int t = 0; t < 26; t++) begin
      tick();
      eg = '0;
      if (t > 0 && (t - 1) % 5 != 4) eg[order[(t - 1) / 5]] = 1'b1;
      n_checks++;
      if (s_grant === eg) n_pass++;
      else $display("FAIL rr_grant_t%0d: got %b, required %b", t, s_grant, eg);
    end
    n_checks++;
    if (sb_idx.size() == 0) n_pass++;
    else $display("FAIL rr_drain: got %0d pending, required 0", sb_idx.size());
  endtask

  task automatic test_full_stall();
    int writes = 0;
    int stall_left = 0;
    bit stall_done = 0;
    bit gap = 0;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      push_word(2, 8'hC0 + 8'(j));
      expect_w(2, 8'hC0 + 8'(j));
    end
    for (int t = 0; t < 10; t++) begin
      tick();
      if (s_wr) writes++;
      if (writes > 0 && writes < 4 && s_grant === '0) gap = 1;
      if (stall_left > 0) begin
        n_checks++;
        if (s_wr === 1'b0 && s_ready === '0 && s_grant === 4'b0100) n_pass++;
        else $display("FAIL full_stall: got wr=%b ready=%b grant=%b, required 0/0000/0100",
                      s_wr, s_ready, s_grant);
        stall_left--;
        if (stall_left == 0) full_drv = 1'b0;
      end else if (writes == 2 && !stall_done) begin
        full_drv   = 1'b1;
        stall_left = 3;
        stall_done = 1;
      end
    end
    n_checks++;
    if (writes == 4 && !gap) n_pass++;
    else $display("FAIL full_total: got writes=%0d gap=%0d, required 4/0", writes, gap);
    n_checks++;
    if (s_grant === '0 && sb_idx.size() == 0) n_pass++;
    else $display("FAIL full_release: got grant=%b pending=%0d, required 0000/0", s_grant, sb_idx.size());
  endtask

  task automatic test_drop();
    do_reset();
    en = 4'b0010;
    push_word(1, 8'h51);
    push_word(0, 8'h01);
    push_word(2, 8'h21);
    expect_w(1, 8'h51);
    expect_w(2, 8'h21);
    expect_w(0, 8'h01);
    tick();
    tick();
    n_checks++;
    if (s_grant === 4'b0010 && s_wr === 1'b1) n_pass++;
    else $display("FAIL drop_grant1: got grant=%b wr=%b, required 0010/1", s_grant, s_wr);
    en = 4'b0111;
    tick();
    n_checks++;
    if (s_grant === 4'b0010 && s_wr === 1'b0 && s_ready === 4'b0010) n_pass++;
    else $display("FAIL drop_hold: got grant=%b wr=%b ready=%b, required 0010/0/0010",
                  s_grant, s_wr, s_ready);
    tick();
    n_checks++;
    if (s_grant === 4'b0000) n_pass++;
    else $display("FAIL drop_release: got %b, required 0000", s_grant);
    tick();
    n_checks++;
    if (s_grant === 4'b0100) n_pass++;
    else $display("FAIL drop_next_winner: got %b, required 0100", s_grant);
    for (int t = 0; t < 10 && sb_idx.size() != 0; t++) tick();
    n_checks++;
    if (sb_idx.size() == 0) n_pass++;
    else $display("FAIL drop_drain: got %0d pending, required 0", sb_idx.size());
  endtask

  task automatic test_reset_mid();
    int writes = 0;
    logic [N-1:0] first_grant = '0;
    do_reset();
    for (int j = 0; j < 4; j++) push_word(0, 8'hE0 + 8'(j));
    expect_w(0, 8'hE0);
    expect_w(0, 8'hE1);
    for (int t = 0; t < 10 && writes < 2; t++) begin
      tick();
      if (s_wr) writes++;
    end
    n_checks++;
    if (writes == 2) n_pass++;
    else $display("FAIL mid_pre_writes: got %0d, required 2", writes);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant === '0 && busy === 1'b0 && fifo_wr_en === 1'b0) n_pass++;
    else $display("FAIL mid_reset_now: got grant=%b busy=%b wr=%b, required 0000/0/0",
                  grant, busy, fifo_wr_en);
    for (int i = 0; i < N; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end
    req_valid = '0;
    push_word(0, 8'h0A);
    push_word(1, 8'h1A);
    expect_w(0, 8'h0A);
    expect_w(1, 8'h1A);
    @(negedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    req_valid    = 4'b0011;
    req_data     = {8'h00, 8'h00, 8'h1A, 8'h0A};
    #1;
    n_checks++;
    if (fifo_wr_en === 1'b0 && grant === '0) n_pass++;
    else $display("FAIL mid_release_cycle: got wr=%b grant=%b, required 0/0000", fifo_wr_en, grant);
    for (int t = 0; t < 15 && sb_idx.size() != 0; t++) begin
      tick();
      if (first_grant === '0 && s_grant !== '0) first_grant = s_grant;
    end
    n_checks++;
    if (first_grant === 4'b0001 && sb_idx.size() == 0) n_pass++;
    else $display("FAIL mid_first_winner: got grant=%b pending=%0d, required 0001/0",
                  first_grant, sb_idx.size());
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    n_checks++;
    if (xfer_count === '0) n_pass++;
    else $display("FAIL stats_reset: got %h, required 0", xfer_count);
    for (int j = 0; j < 10; j++) begin
      push_word(3, 8'h30 + 8'(j));
      expect_w(3, 8'h30 + 8'(j));
    end
    for (int t = 0; t < 30 && sb_idx.size() != 0; t++) tick();
    tick();
    n_checks++;
    if (xfer_count === {16'd10, 16'd0, 16'd0, 16'd0}) n_pass++;
    else $display("FAIL stats_count10: got %h, required 000a000000000000", xfer_count);
    push_word(3, 8'h3A);
    push_word(3, 8'h3B);
    expect_w(3, 8'h3A);
    expect_w(3, 8'h3B);
    tick();
    clr_drv = 1'b1;
    tick();
    clr_drv = 1'b0;
    n_checks++;
    if (s_wr === 1'b1 && xfer_count[63:48] === 16'd10) n_pass++;
    else $display("FAIL stats_pre_clr: got wr=%b cnt=%0d, required 1/10", s_wr, xfer_count[63:48]);
    tick();
    n_checks++;
    if (xfer_count[63:48] === 16'd0) n_pass++;
    else $display("FAIL stats_clr_wins: got %0d, required 0", xfer_count[63:48]);
    tick();
    n_checks++;
    if (xfer_count[63:48] === 16'd1) n_pass++;
    else $display("FAIL stats_after_clr: got %0d, required 1", xfer_count[63:48]);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop();
    test_reset_mid();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
